// File: rtl/target_scheduler.sv
// Round sequencer for the whack-a-target game: picks targets from the random
// generator, times each target's lifetime, scores pad hits and counts misses.
module target_scheduler #(
  parameter int unsigned LIFE_CYCLES   = 50000000,
  parameter int unsigned LIFE_MIN      = 12500000,
  parameter int unsigned LIFE_STEP     = 5000000,
  parameter int unsigned HITS_PER_STEP = 10,
  parameter int unsigned GAP_CYCLES    = 10000000,
  parameter int unsigned MAX_MISSES    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  ran_num,
  input  logic [9:0]  hit,
  output logic [9:0]  target,
  output logic [31:0] score,
  output logic [3:0]  misses,
  output logic [31:0] gen_modulus,
  output logic        game_over,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, PICK, SHOW, GAP, OVER} state_t;

  localparam logic [31:0] LIFE_INIT  = 32'(LIFE_CYCLES);
  localparam logic [31:0] LIFE_FLOOR = 32'(LIFE_MIN);
  localparam logic [31:0] LIFE_DEC   = 32'(LIFE_STEP);
  localparam logic [31:0] STEP_HITS  = 32'(HITS_PER_STEP);
  localparam logic [31:0] GAP_LOAD   = 32'(GAP_CYCLES);
  localparam logic [3:0]  MISS_LIMIT = 4'(MAX_MISSES);
  localparam logic [3:0]  NO_INDEX   = 4'hF;

  state_t      state_q, state_d;
  logic [9:0]  target_q, target_d;
  logic [31:0] score_q, score_d;
  logic [3:0]  misses_q, misses_d;
  logic [31:0] life_q, life_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [3:0]  last_idx_q, last_idx_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] timer_q, timer_d;
  logic [9:0]  hit_q;
  logic [9:0]  press;
  logic        lit_press;

  // Only rising edges count, so a pad held down into SHOW never scores.
  assign press     = hit & ~hit_q;
  assign lit_press = |(press & target_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      target_q   <= '0;
      score_q    <= '0;
      misses_q   <= '0;
      life_q     <= LIFE_INIT;
      hit_cnt_q  <= '0;
      last_idx_q <= NO_INDEX;
      idx_q      <= '0;
      timer_q    <= '0;
      hit_q      <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
      life_q     <= life_d;
      hit_cnt_q  <= hit_cnt_d;
      last_idx_q <= last_idx_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      hit_q      <= hit;
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    score_d    = score_q;
    misses_d   = misses_q;
    life_d     = life_q;
    hit_cnt_d  = hit_cnt_q;
    last_idx_d = last_idx_q;
    idx_d      = idx_q;
    timer_d    = timer_q;

    case (state_q)
      IDLE, OVER: begin
        // Last index returns to the "none" value so any first target is allowed.
        if (start) begin
          score_d    = '0;
          misses_d   = '0;
          hit_cnt_d  = '0;
          last_idx_d = NO_INDEX;
          life_d     = LIFE_INIT;
          state_d    = PICK;
        end
      end

      PICK: begin
        if (ran_num <= 4'd9 && ran_num != last_idx_q) begin
          idx_d    = ran_num;
          target_d = 10'd1 << ran_num;
          timer_d  = life_q;
          state_d  = SHOW;
        end
      end

      SHOW: begin
        // A correct press wins over an expiring timer in the same cycle.
        if (lit_press) begin
          score_d  = (score_q == '1) ? score_q : score_q + 32'd1;
          target_d = '0;
          timer_d  = GAP_LOAD;
          state_d  = GAP;
          if (hit_cnt_q + 32'd1 >= STEP_HITS) begin
            hit_cnt_d = '0;
            life_d    = (life_q >= LIFE_FLOOR + LIFE_DEC) ? life_q - LIFE_DEC : LIFE_FLOOR;
          end else begin
            hit_cnt_d = hit_cnt_q + 32'd1;
          end
        end else if (timer_q == '0) begin
          misses_d = misses_q + 4'd1;
          target_d = '0;
          if (misses_q + 4'd1 >= MISS_LIMIT) begin
            state_d = OVER;
          end else begin
            timer_d = GAP_LOAD;
            state_d = GAP;
          end
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end

      GAP: begin
        if (timer_q == '0) begin
          last_idx_d = idx_q;
          state_d    = PICK;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign target      = target_q;
  assign score       = score_q;
  assign misses      = misses_q;
  assign gen_modulus = score_q + 32'd11;
  assign game_over   = (state_q == OVER);
  assign busy        = (state_q == PICK) || (state_q == SHOW) || (state_q == GAP);

endmodule

// File: tb/tb_target_scheduler.sv
// Directed bench for target_scheduler with shortened timing parameters;
// inputs change and outputs are checked on the falling clock edge.
module tb_target_scheduler;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  ran_num;
  logic [9:0]  hit;
  logic [9:0]  target;
  logic [31:0] score;
  logic [3:0]  misses;
  logic [31:0] gen_modulus;
  logic        game_over;
  logic        busy;

  int checks_total  = 0;
  int checks_passed = 0;

  target_scheduler #(
    .LIFE_CYCLES(8),
    .LIFE_MIN(4),
    .LIFE_STEP(2),
    .HITS_PER_STEP(2),
    .GAP_CYCLES(4),
    .MAX_MISSES(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .ran_num(ran_num),
    .hit(hit),
    .target(target),
    .score(score),
    .misses(misses),
    .gen_modulus(gen_modulus),
    .game_over(game_over),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] r, input logic [9:0] h);
    start   = s;
    ran_num = r;
    hit     = h;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Stops on the first falling edge where a target is lit, within a cycle budget.
  task automatic waitTarget(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (target != '0) found = 1'b1;
    end
    checkOutput(tag, {31'd0, found}, 32'd1);
  endtask

  initial begin
    applyStimulus(1'b0, 4'd0, 10'h000);
    reset = 1'b1;
    tick(2);
    checkOutput("rst_target", 32'(target), 32'h0);
    checkOutput("rst_score", score, 32'h0);
    checkOutput("rst_misses", 32'(misses), 32'h0);
    checkOutput("rst_game_over", 32'(game_over), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_modulus", gen_modulus, 32'd11);
    reset = 1'b0;

    applyStimulus(1'b1, 4'd3, 10'h000);
    tick(1);
    applyStimulus(1'b0, 4'd3, 10'h000);
    checkOutput("pick_busy", 32'(busy), 32'h1);
    checkOutput("pick_dark", 32'(target), 32'h0);
    tick(1);
    checkOutput("show3_target", 32'(target), 32'h008);
    checkOutput("show3_score", score, 32'h0);
    checkOutput("show3_modulus", gen_modulus, 32'd11);

    tick(1);
    hit = 10'h008;
    tick(1);
    hit = 10'h000;
    checkOutput("hit3_score", score, 32'd1);
    checkOutput("hit3_target", 32'(target), 32'h0);
    checkOutput("hit3_modulus", gen_modulus, 32'd12);
    ran_num = 4'd5;
    tick(5);
    checkOutput("gap_dark", 32'(target), 32'h0);
    tick(1);
    checkOutput("pick5_target", 32'(target), 32'h020);

    hit = 10'h008;
    tick(1);
    hit = 10'h000;
    checkOutput("wrong_pad_score", score, 32'd1);
    checkOutput("wrong_pad_target", 32'(target), 32'h020);
    tick(7);
    checkOutput("show_last_target", 32'(target), 32'h020);
    checkOutput("show_last_misses", 32'(misses), 32'h0);
    tick(1);
    checkOutput("miss1_misses", 32'(misses), 32'd1);
    checkOutput("miss1_target", 32'(target), 32'h0);
    checkOutput("miss1_busy", 32'(busy), 32'h1);

    ran_num = 4'd1;
    tick(6);
    checkOutput("pick1_target", 32'(target), 32'h002);
    tick(9);
    checkOutput("miss2_misses", 32'(misses), 32'd2);
    ran_num = 4'd0;
    tick(6);
    checkOutput("pick0_target", 32'(target), 32'h001);
    tick(9);
    checkOutput("over_game_over", 32'(game_over), 32'h1);
    checkOutput("over_busy", 32'(busy), 32'h0);
    checkOutput("over_target", 32'(target), 32'h0);
    checkOutput("over_misses", 32'(misses), 32'd3);
    checkOutput("over_score", score, 32'd1);

    applyStimulus(1'b1, 4'd3, 10'h000);
    tick(1);
    start = 1'b0;
    checkOutput("restart_score", score, 32'h0);
    checkOutput("restart_misses", 32'(misses), 32'h0);
    checkOutput("restart_game_over", 32'(game_over), 32'h0);
    checkOutput("restart_busy", 32'(busy), 32'h1);
    tick(1);
    checkOutput("restart_target", 32'(target), 32'h008);
    hit = 10'h008;
    tick(1);
    hit = 10'h000;
    checkOutput("restart_hit_score", score, 32'd1);

    ran_num = 4'd12;
    tick(6);
    checkOutput("dwell_reject_range", 32'(target), 32'h0);
    ran_num = 4'd3;
    tick(1);
    checkOutput("dwell_reject_repeat", 32'(target), 32'h0);
    ran_num = 4'd7;
    tick(1);
    checkOutput("dwell_accept", 32'(target), 32'h080);

    hit = 10'h080;
    tick(1);
    hit = 10'h000;
    checkOutput("speedup_score", score, 32'd2);
    ran_num = 4'd2;
    tick(6);
    checkOutput("fast_show_target", 32'(target), 32'h004);
    tick(6);
    checkOutput("fast_show_last", 32'(target), 32'h004);
    tick(1);
    checkOutput("fast_show_miss", 32'(misses), 32'd1);
    checkOutput("fast_show_dark", 32'(target), 32'h0);

    for (int k = 0; k < 6; k++) begin
      ran_num = (k % 2 == 0) ? 4'd4 : 4'd5;
      waitTarget("hit_loop_wait");
      hit = target;
      tick(1);
      hit = 10'h000;
      checkOutput("hit_loop_score", score, 32'(3 + k));
    end
    checkOutput("hit_loop_modulus", gen_modulus, 32'd19);

    ran_num = 4'd6;
    waitTarget("clamp_wait");
    checkOutput("clamp_target", 32'(target), 32'h040);
    tick(4);
    checkOutput("clamp_last", 32'(target), 32'h040);
    tick(1);
    checkOutput("clamp_miss", 32'(misses), 32'd2);
    checkOutput("clamp_dark", 32'(target), 32'h0);

    ran_num = 4'd7;
    waitTarget("zero_hit_wait");
    tick(4);
    checkOutput("zero_hit_lit", 32'(target), 32'h080);
    hit = 10'h080;
    tick(1);
    hit = 10'h000;
    checkOutput("zero_hit_score", score, 32'd9);
    checkOutput("zero_hit_misses", 32'(misses), 32'd2);
    checkOutput("zero_hit_target", 32'(target), 32'h0);

    ran_num = 4'd1;
    waitTarget("reset_wait");
    tick(2);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_target", 32'(target), 32'h0);
    checkOutput("async_rst_busy", 32'(busy), 32'h0);
    checkOutput("async_rst_game_over", 32'(game_over), 32'h0);
    checkOutput("async_rst_score", score, 32'h0);
    checkOutput("async_rst_misses", 32'(misses), 32'h0);
    hit = 10'h004;
    tick(2);
    reset = 1'b0;
    tick(1);
    applyStimulus(1'b1, 4'd2, 10'h004);
    tick(1);
    start = 1'b0;
    tick(1);
    checkOutput("held_pad_target", 32'(target), 32'h004);
    tick(3);
    checkOutput("held_pad_score", score, 32'h0);
    hit = 10'h000;
    tick(1);
    hit = 10'h004;
    tick(1);
    hit = 10'h000;
    checkOutput("repress_score", score, 32'd1);
    checkOutput("repress_target", 32'(target), 32'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
